riffa_chnl_tester: RTL and testbench

//  RIFFA PCIe channel loopback tester. Receives one RX transaction of 128-bit beats into
//  an internal buffer (rBuff, BUFF_SIZE entries), then returns it as one TX transaction

---
 rtl/riffa_chnl_tester_if.sv | 41 ++++
 rtl/riffa_chnl_tester.sv | 161 ++++++++++++++++
 tb/tb_riffa_chnl_tester.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/riffa_chnl_tester_if.sv
// One RIFFA channel: RX and TX transaction handshakes plus their data streams.
// "slave" is the user core behind the channel, "master" is the RIFFA host side.
interface riffa_chnl_tester_if #(
   parameter int C_PCI_DATA_WIDTH = 128
);
   logic                        CHNL_RX_CLK;
   logic                        CHNL_RX;
   logic                        CHNL_RX_ACK;
   logic                        CHNL_RX_LAST;
   logic [31:0]                 CHNL_RX_LEN;
   logic [30:0]                 CHNL_RX_OFF;
   logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA;
   logic                        CHNL_RX_DATA_VALID;
   logic                        CHNL_RX_DATA_REN;

   logic                        CHNL_TX_CLK;
   logic                        CHNL_TX;
   logic                        CHNL_TX_ACK;
   logic                        CHNL_TX_LAST;
   logic [31:0]                 CHNL_TX_LEN;
   logic [30:0]                 CHNL_TX_OFF;
   logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA;
   logic                        CHNL_TX_DATA_VALID;
   logic                        CHNL_TX_DATA_REN;

   modport slave (
      output CHNL_RX_CLK, CHNL_RX_ACK, CHNL_RX_DATA_REN,
      output CHNL_TX_CLK, CHNL_TX, CHNL_TX_LAST, CHNL_TX_LEN, CHNL_TX_OFF,
      output CHNL_TX_DATA, CHNL_TX_DATA_VALID,
      input  CHNL_RX, CHNL_RX_LAST, CHNL_RX_LEN, CHNL_RX_OFF, CHNL_RX_DATA,
      input  CHNL_RX_DATA_VALID, CHNL_TX_ACK, CHNL_TX_DATA_REN
   );

   modport master (
      input  CHNL_RX_CLK, CHNL_RX_ACK, CHNL_RX_DATA_REN,
      input  CHNL_TX_CLK, CHNL_TX, CHNL_TX_LAST, CHNL_TX_LEN, CHNL_TX_OFF,
      input  CHNL_TX_DATA, CHNL_TX_DATA_VALID,
      output CHNL_RX, CHNL_RX_LAST, CHNL_RX_LEN, CHNL_RX_OFF, CHNL_RX_DATA,
      output CHNL_RX_DATA_VALID, CHNL_TX_ACK, CHNL_TX_DATA_REN
   );
endinterface

// File: rtl/riffa_chnl_tester.sv
// RIFFA channel loopback tester: buffers one RX transaction, then sends it back as one
// TX transaction with every 128-bit beat incremented by 3.
module riffa_chnl_tester #(
   parameter int C_PCI_DATA_WIDTH = 128,
   parameter int BUFF_SIZE        = 10
) (
   input  logic                        CLK,
   input  logic                        RST,
   riffa_chnl_tester_if.slave          chnl,
   output logic [C_PCI_DATA_WIDTH-1:0] MEM_0,
   output logic [C_PCI_DATA_WIDTH-1:0] MEM_1,
   output logic [C_PCI_DATA_WIDTH-1:0] MEM_2,
   output logic [C_PCI_DATA_WIDTH-1:0] MEM_3,
   output logic [C_PCI_DATA_WIDTH-1:0] MEM_4,
   output logic [C_PCI_DATA_WIDTH-1:0] MEM_5,
   output logic [C_PCI_DATA_WIDTH-1:0] MEM_6,
   output logic [C_PCI_DATA_WIDTH-1:0] MEM_7,
   output logic [C_PCI_DATA_WIDTH-1:0] MEM_8,
   output logic [C_PCI_DATA_WIDTH-1:0] MEM_9,
   output logic [2:0]                  STATO_FSM,
   output logic [31:0]                 ITER,
   output logic [31:0]                 CNT,
   output logic [31:0]                 RXLEN,
   output logic [31:0]                 TXLEN
);

   // The debug ports always expose ten entries, so the array never shrinks below that.
   localparam int MEM_DEPTH = (BUFF_SIZE > 10) ? BUFF_SIZE : 10;
   localparam int IDX_W     = $clog2(MEM_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RX   = 3'd1,
      S_PREP = 3'd2,
      S_TX   = 3'd3
   } state_t;

   state_t                      state_q, state_d;
   logic [31:0]                 cnt_q, cnt_d;
   logic [31:0]                 rxlen_q, rxlen_d;
   logic [31:0]                 txlen_q, txlen_d;
   logic [31:0]                 iter_q, iter_d;
   logic [C_PCI_DATA_WIDTH-1:0] rbuff_q [MEM_DEPTH];
   logic [C_PCI_DATA_WIDTH-1:0] rbuff_d [MEM_DEPTH];

   logic [29:0]                 beat_idx;
   logic [IDX_W-1:0]            buf_sel;
   logic                        idx_in_buf;
   logic                        tx_active;
   logic [C_PCI_DATA_WIDTH-1:0] tx_word;
   logic                        unused_inputs;

   // CNT counts 32-bit words, so the beat index is CNT/4 in both directions.
   assign beat_idx   = cnt_q[31:2];
   assign buf_sel    = cnt_q[IDX_W+1:2];
   assign idx_in_buf = (beat_idx < 30'(BUFF_SIZE));
   assign tx_active  = (state_q == S_TX);
   assign tx_word    = idx_in_buf ? (rbuff_q[buf_sel] + C_PCI_DATA_WIDTH'(3))
                                  : C_PCI_DATA_WIDTH'(3);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rxlen_d = rxlen_q;
      txlen_d = txlen_q;
      iter_d  = iter_q;
      rbuff_d = rbuff_q;
      case (state_q)
         S_IDLE: begin
            if (chnl.CHNL_RX) begin
               rxlen_d = chnl.CHNL_RX_LEN;
               cnt_d   = '0;
               state_d = S_RX;
            end
         end
         S_RX: begin
            if (chnl.CHNL_RX_DATA_VALID) begin
               if (idx_in_buf) begin
                  rbuff_d[buf_sel] = chnl.CHNL_RX_DATA;
               end
               cnt_d = cnt_q + 32'd4;
            end
            if (cnt_q >= rxlen_q) begin
               state_d = S_PREP;
            end
         end
         S_PREP: begin
            txlen_d = rxlen_q;
            cnt_d   = '0;
            if (rxlen_q == 32'd0) begin
               iter_d  = iter_q + 32'd1;
               state_d = S_IDLE;
            end else begin
               state_d = S_TX;
            end
         end
         S_TX: begin
            if (chnl.CHNL_TX_DATA_REN) begin
               cnt_d = cnt_q + 32'd4;
               if ((cnt_q + 32'd4) >= txlen_q) begin
                  iter_d  = iter_q + 32'd1;
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rxlen_q <= '0;
         txlen_q <= '0;
         iter_q  <= '0;
         for (int k = 0; k < MEM_DEPTH; k++) begin
            rbuff_q[k] <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rxlen_q <= rxlen_d;
         txlen_q <= txlen_d;
         iter_q  <= iter_d;
         rbuff_q <= rbuff_d;
      end
   end

   assign chnl.CHNL_RX_CLK        = CLK;
   assign chnl.CHNL_TX_CLK        = CLK;
   assign chnl.CHNL_RX_ACK        = (state_q == S_RX);
   assign chnl.CHNL_RX_DATA_REN   = (state_q == S_RX);

   // TX lines are held at zero outside TX so the idle bus is quiet after reset.
   assign chnl.CHNL_TX            = tx_active;
   assign chnl.CHNL_TX_LAST       = tx_active;
   assign chnl.CHNL_TX_LEN        = tx_active ? txlen_q : 32'd0;
   assign chnl.CHNL_TX_OFF        = 31'd0;
   assign chnl.CHNL_TX_DATA       = tx_active ? tx_word : '0;
   assign chnl.CHNL_TX_DATA_VALID = tx_active;

   assign unused_inputs = &{1'b0, chnl.CHNL_RX_LAST, chnl.CHNL_RX_OFF, chnl.CHNL_TX_ACK};

   assign MEM_0     = rbuff_q[0];
   assign MEM_1     = rbuff_q[1];
   assign MEM_2     = rbuff_q[2];
   assign MEM_3     = rbuff_q[3];
   assign MEM_4     = rbuff_q[4];
   assign MEM_5     = rbuff_q[5];
   assign MEM_6     = rbuff_q[6];
   assign MEM_7     = rbuff_q[7];
   assign MEM_8     = rbuff_q[8];
   assign MEM_9     = rbuff_q[9];
   assign STATO_FSM = state_q;
   assign ITER      = iter_q;
   assign CNT       = cnt_q;
   assign RXLEN     = rxlen_q;
   assign TXLEN     = txlen_q;

endmodule

// File: tb/tb_riffa_chnl_tester.sv
// Self-checking bench for riffa_chnl_tester: drives RX transactions as the host, collects
// the looped-back TX beats and compares them with a simple buffer model.
module tb_riffa_chnl_tester;

   logic         clk;
   logic         rst_n;
   logic [127:0] mem_obs [10];
   logic [2:0]   stato;
   logic [31:0]  iter_obs;
   logic [31:0]  cnt_obs;
   logic [31:0]  rxlen_obs;
   logic [31:0]  txlen_obs;

   int           checks;
   int           errors;
   logic [127:0] model_mem [10];
   int           model_iter;
   logic [127:0] rx_beats [16];

   riffa_chnl_tester_if #(.C_PCI_DATA_WIDTH(128)) chnl ();

   riffa_chnl_tester #(
      .C_PCI_DATA_WIDTH(128),
      .BUFF_SIZE(10)
   ) dut (
      .CLK       (clk),
      .RST       (rst_n),
      .chnl      (chnl),
      .MEM_0     (mem_obs[0]),
      .MEM_1     (mem_obs[1]),
      .MEM_2     (mem_obs[2]),
      .MEM_3     (mem_obs[3]),
      .MEM_4     (mem_obs[4]),
      .MEM_5     (mem_obs[5]),
      .MEM_6     (mem_obs[6]),
      .MEM_7     (mem_obs[7]),
      .MEM_8     (mem_obs[8]),
      .MEM_9     (mem_obs[9]),
      .STATO_FSM (stato),
      .ITER      (iter_obs),
      .CNT       (cnt_obs),
      .RXLEN     (rxlen_obs),
      .TXLEN     (txlen_obs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected loopback beat k: stored beats come back +3 (wrapping), beyond the buffer just 3.
   function automatic logic [127:0] expectedBeat(input int k);
      if (k < 10) return model_mem[k] + 128'd3;
      return 128'd3;
   endfunction

   task automatic checkMemory(input string tag);
      for (int k = 0; k < 10; k++) begin
         checkOutput($sformatf("%s_mem%0d", tag, k), mem_obs[k], model_mem[k]);
      end
   endtask

   task automatic resetDut();
      rst_n = 1'b0;
      chnl.CHNL_RX = 1'b0;
      chnl.CHNL_RX_DATA_VALID = 1'b0;
      chnl.CHNL_TX_DATA_REN = 1'b0;
      chnl.CHNL_TX_ACK = 1'b0;
      @(negedge clk);
      @(negedge clk);
      for (int k = 0; k < 10; k++) model_mem[k] = '0;
      model_iter = 0;
      checkOutput("rst_state", 128'(stato), 128'(0));
      checkOutput("rst_iter", 128'(iter_obs), 128'(0));
      checkOutput("rst_cnt", 128'(cnt_obs), 128'(0));
      checkOutput("rst_rxlen", 128'(rxlen_obs), 128'(0));
      checkOutput("rst_txlen", 128'(txlen_obs), 128'(0));
      checkOutput("rst_rx_ack", 128'(chnl.CHNL_RX_ACK), 128'(0));
      checkOutput("rst_tx_req", 128'(chnl.CHNL_TX), 128'(0));
      checkOutput("rst_tx_valid", 128'(chnl.CHNL_TX_DATA_VALID), 128'(0));
      checkOutput("rst_tx_data", chnl.CHNL_TX_DATA, 128'(0));
      checkMemory("rst");
      rst_n = 1'b1;
   endtask

   // Host side of an RX transaction; sends at most max_beats beats of rx_beats[].
   task automatic applyStimulus(input int len, input int max_beats, input bit gaps);
      int  needed;
      int  send;
      int  sent;
      int  cyc;
      logic val_now;
      logic ren_now;
      needed = (len + 3) / 4;
      send   = (max_beats < needed) ? max_beats : needed;
      chnl.CHNL_RX      = 1'b1;
      chnl.CHNL_RX_LEN  = 32'(len);
      chnl.CHNL_RX_LAST = 1'b1;
      chnl.CHNL_RX_OFF  = 31'($urandom);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!chnl.CHNL_RX_ACK && cyc < 20);
      checkOutput("rx_ack", 128'(chnl.CHNL_RX_ACK), 128'(1));
      chnl.CHNL_RX = 1'b0;
      sent = 0;
      cyc  = 0;
      while (sent < send && cyc < 400) begin
         val_now = !(gaps && ($urandom_range(0, 3) == 0));
         chnl.CHNL_RX_DATA_VALID = val_now;
         chnl.CHNL_RX_DATA = val_now ? rx_beats[sent] : '0;
         ren_now = chnl.CHNL_RX_DATA_REN;
         @(negedge clk);
         if (val_now && ren_now) begin
            if (sent < 10) model_mem[sent] = rx_beats[sent];
            sent++;
         end
         cyc++;
      end
      chnl.CHNL_RX_DATA_VALID = 1'b0;
      checkOutput("rx_beats_sent", 128'(sent), 128'(send));
      if (send == needed) begin
         checkOutput("rx_state_rx", 128'(stato), 128'(1));
         checkOutput("rx_len_latch", 128'(rxlen_obs), 128'(len));
         checkOutput("rx_cnt", 128'(cnt_obs), 128'(4 * needed));
         @(negedge clk);
         checkOutput("rx_state_prep", 128'(stato), 128'(2));
         @(negedge clk);
         if (len == 0) begin
            model_iter++;
            checkOutput("rx0_state_idle", 128'(stato), 128'(0));
            checkOutput("rx0_iter", 128'(iter_obs), 128'(model_iter));
         end else begin
            checkOutput("rx_state_tx", 128'(stato), 128'(3));
            checkOutput("rx_txlen", 128'(txlen_obs), 128'(len));
            checkOutput("rx_cnt_clr", 128'(cnt_obs), 128'(0));
         end
         checkMemory("rx");
      end
   endtask

   // Host side of the TX transaction; ren_mode 0 = held after first cycle, 1 = toggling, 2 = random.
   task automatic collectTx(input int len, input int ren_mode);
      int   needed;
      int   got;
      int   cyc;
      logic ren;
      needed = (len + 3) / 4;
      checkOutput("tx_req", 128'(chnl.CHNL_TX), 128'(1));
      checkOutput("tx_last", 128'(chnl.CHNL_TX_LAST), 128'(1));
      checkOutput("tx_len", 128'(chnl.CHNL_TX_LEN), 128'(len));
      checkOutput("tx_off", 128'(chnl.CHNL_TX_OFF), 128'(0));
      checkOutput("tx_valid_early", 128'(chnl.CHNL_TX_DATA_VALID), 128'(1));
      chnl.CHNL_TX_ACK = 1'b1;
      got = 0;
      cyc = 0;
      while (got < needed && cyc < 400) begin
         case (ren_mode)
            0:       ren = (cyc > 0);
            1:       ren = ((cyc % 2) == 0);
            default: ren = 1'($urandom_range(0, 1));
         endcase
         chnl.CHNL_TX_DATA_REN = ren;
         if (cyc == 1) chnl.CHNL_TX_ACK = 1'b0;
         if (ren && chnl.CHNL_TX_DATA_VALID) begin
            checkOutput($sformatf("tx_beat%0d", got), chnl.CHNL_TX_DATA, expectedBeat(got));
            got++;
         end
         @(negedge clk);
         cyc++;
      end
      chnl.CHNL_TX_DATA_REN = 1'b0;
      chnl.CHNL_TX_ACK = 1'b0;
      model_iter++;
      checkOutput("tx_beats_got", 128'(got), 128'(needed));
      checkOutput("tx_done_state", 128'(stato), 128'(0));
      checkOutput("tx_done_valid", 128'(chnl.CHNL_TX_DATA_VALID), 128'(0));
      checkOutput("tx_iter", 128'(iter_obs), 128'(model_iter));
   endtask

   initial begin
      int len;
      checks = 0;
      errors = 0;
      chnl.CHNL_RX_LEN  = '0;
      chnl.CHNL_RX_OFF  = '0;
      chnl.CHNL_RX_LAST = 1'b0;
      chnl.CHNL_RX_DATA = '0;

      $display("[TB] reset");
      resetDut();

      $display("[TB] pass 1: beats 100..10");
      for (int k = 0; k < 10; k++) rx_beats[k] = 128'(100 - 10 * k);
      applyStimulus(40, 16, 1'b0);
      collectTx(40, 0);

      $display("[TB] pass 2: beats 1..10, toggling REN");
      for (int k = 0; k < 10; k++) rx_beats[k] = 128'(k + 1);
      applyStimulus(40, 16, 1'b0);
      collectTx(40, 1);

      $display("[TB] zero-length transaction");
      applyStimulus(0, 16, 1'b0);

      $display("[TB] length 41: eleventh beat falls outside the buffer");
      for (int k = 0; k < 16; k++) rx_beats[k] = {$urandom, $urandom, $urandom, $urandom};
      rx_beats[0] = '1;
      applyStimulus(41, 16, 1'b0);
      collectTx(41, 0);

      for (int p = 0; p < 5; p++) begin
         len = $urandom_range(1, 64);
         $display("[TB] random pass %0d len %0d", p, len);
         for (int k = 0; k < 16; k++) rx_beats[k] = {$urandom, $urandom, $urandom, $urandom};
         applyStimulus(len, 16, 1'b1);
         collectTx(len, 2);
      end

      $display("[TB] reset in the middle of RX");
      for (int k = 0; k < 10; k++) rx_beats[k] = 128'(500 + k);
      applyStimulus(40, 3, 1'b0);
      checkOutput("midrx_cnt_before", 128'(cnt_obs), 128'(12));
      rst_n = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 10; k++) model_mem[k] = '0;
      model_iter = 0;
      checkOutput("midrx_state", 128'(stato), 128'(0));
      checkOutput("midrx_cnt", 128'(cnt_obs), 128'(0));
      checkOutput("midrx_iter", 128'(iter_obs), 128'(0));
      checkMemory("midrx");
      rst_n = 1'b1;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
